// File: rtl/frame_loader.sv
// frame_loader: packs 32-bit stream words MSB-first into 276-bit frames.
// Double-buffered: the next frame fills while the current one is presented.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   i_flush           synchronous clear of both buffers
//   i_word/i_valid    input word and its valid strobe
//   i_last            marks the final word of the stream
//   o_ready           word accepted this cycle when i_valid is also high
//   o_frame           presented frame, bit FRAME_W-1 received first
//   o_frame_bits      number of valid bits in o_frame
//   o_frame_valid     presented frame is valid and held stable
//   o_frame_last      presented frame was closed by i_last
//   i_frame_ack       slicer has consumed the presented frame
module frame_loader #(
  parameter  int FRAME_W         = 276,
  parameter  int WORD_W          = 32,
  localparam int WORDS_PER_FRAME = (FRAME_W + WORD_W - 1) / WORD_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_flush,
  input  logic [WORD_W-1:0]  i_word,
  input  logic               i_valid,
  input  logic               i_last,
  output logic               o_ready,
  output logic [FRAME_W-1:0] o_frame,
  output logic [8:0]         o_frame_bits,
  output logic               o_frame_valid,
  output logic               o_frame_last,
  input  logic               i_frame_ack
);

  localparam int LAST_K    = WORDS_PER_FRAME - 1;
  localparam int LAST_BITS = FRAME_W - WORD_W * LAST_K;
  localparam int CNT_W     = $clog2(WORDS_PER_FRAME);

  logic [FRAME_W-1:0] fill_q;
  logic [CNT_W-1:0]   wcnt_q;
  logic               fill_full_q;
  logic [8:0]         fill_bits_q;
  logic               fill_last_q;

  logic               accept;
  logic               done;
  logic               load;
  logic [8:0]         bits_next;

  // The final word only contributes its top bits; the rest is dropped.
  logic unused_lsbs;
  assign unused_lsbs = ^i_word[WORD_W-LAST_BITS-1:0];

  assign o_ready = !fill_full_q;
  assign accept  = i_valid && !fill_full_q;
  assign done    = (int'(wcnt_q) == LAST_K) || i_last;
  assign load    = fill_full_q && (!o_frame_valid || i_frame_ack);

  always_comb begin
    bits_next = 9'((int'(wcnt_q) + 1) * WORD_W);
    if (int'(wcnt_q) == LAST_K)
      bits_next = 9'(FRAME_W);
  end

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      fill_q        <= '0;
      wcnt_q        <= '0;
      fill_full_q   <= 1'b0;
      fill_bits_q   <= '0;
      fill_last_q   <= 1'b0;
      o_frame       <= '0;
      o_frame_bits  <= '0;
      o_frame_valid <= 1'b0;
      o_frame_last  <= 1'b0;
    end else begin
      // load and accept are exclusive: both depend on fill_full_q.
      if (load) begin
        o_frame       <= fill_q;
        o_frame_bits  <= fill_bits_q;
        o_frame_last  <= fill_last_q;
        o_frame_valid <= 1'b1;
        fill_full_q   <= 1'b0;
        fill_q        <= '0;
      end else if (o_frame_valid && i_frame_ack) begin
        o_frame_valid <= 1'b0;
      end

      if (accept) begin
        for (int k = 0; k < LAST_K; k++) begin
          if (int'(wcnt_q) == k)
            fill_q[FRAME_W-1-WORD_W*k -: WORD_W] <= i_word;
        end
        if (int'(wcnt_q) == LAST_K)
          fill_q[LAST_BITS-1:0] <= i_word[WORD_W-1 -: LAST_BITS];

        if (done) begin
          fill_full_q <= 1'b1;
          fill_bits_q <= bits_next;
          fill_last_q <= i_last;
          wcnt_q      <= '0;
        end else begin
          wcnt_q      <= wcnt_q + 1'b1;
        end
      end
    end
  end

endmodule
